mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 119 +++++++++++
 tb/tb_mem_arbiter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_arbiter : I/D cache line arbiter with one-entry write-back buffer. Rev 1.0
// ---------------------------------------------------------------------------
module mem_arbiter #(
  parameter int LADDR_BITS = 16,
  parameter int LINE_BITS  = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Ic_mem_req,
  input  logic [LADDR_BITS-1:0] Ic_mem_addr,
  output logic [LINE_BITS-1:0]  F_mem_inst,
  output logic                  F_mem_valid,
  input  logic                  Dc_mem_req,
  input  logic [LADDR_BITS-1:0] Dc_mem_addr,
  output logic [LINE_BITS-1:0]  MEM_data_line,
  output logic                  MEM_mem_valid,
  input  logic                  Dc_wb_we,
  input  logic [LADDR_BITS-1:0] Dc_wb_addr,
  input  logic [LINE_BITS-1:0]  Dc_wb_wline,
  output logic                  Arb_mem_req,
  output logic                  Arb_mem_we,
  output logic [LADDR_BITS-1:0] Arb_mem_addr,
  output logic [LINE_BITS-1:0]  Arb_mem_wline,
  input  logic [LINE_BITS-1:0]  Arb_mem_rline,
  input  logic                  Arb_mem_valid,
  output logic                  Arb_wb_overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    RD_I = 2'd2,
    RD_D = 2'd3
  } state_t;

  state_t                  state, state_nxt;
  logic                    buf_valid;
  logic [LADDR_BITS-1:0]   buf_addr;
  logic [LINE_BITS-1:0]    buf_line;
  logic                    last_i;
  logic                    ir, dr, grant_i, grant_d, grant_wb, drain;

  always_comb begin
    state_nxt = state;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    grant_wb  = 1'b0;
    // A client whose valid is high this cycle is still holding its old request.
    ir        = Ic_mem_req & ~F_mem_valid;
    dr        = Dc_mem_req & ~MEM_mem_valid;
    drain     = (state == WB) & Arb_mem_valid;
    case (state)
      IDLE: begin
        if (buf_valid) begin
          grant_wb  = 1'b1;
          state_nxt = WB;
        end else if (!Dc_wb_we) begin
          // An incoming write-back blocks reads until it has been drained.
          grant_i = ir & (~dr | ~last_i);
          grant_d = dr & ~grant_i;
          if (grant_i)      state_nxt = RD_I;
          else if (grant_d) state_nxt = RD_D;
        end
      end
      default: if (Arb_mem_valid) state_nxt = IDLE;
    endcase
  end

  assign Arb_mem_req = (state != IDLE);
  assign Arb_mem_we  = (state == WB);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      buf_valid       <= 1'b0;
      buf_addr        <= '0;
      buf_line        <= '0;
      last_i          <= 1'b0;
      Arb_mem_addr    <= '0;
      Arb_mem_wline   <= '0;
      F_mem_inst      <= '0;
      F_mem_valid     <= 1'b0;
      MEM_data_line   <= '0;
      MEM_mem_valid   <= 1'b0;
      Arb_wb_overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      if (grant_wb) begin
        Arb_mem_addr  <= buf_addr;
        Arb_mem_wline <= buf_line;
      end else if (grant_i) begin
        Arb_mem_addr <= Ic_mem_addr;
        last_i       <= 1'b1;
      end else if (grant_d) begin
        Arb_mem_addr <= Dc_mem_addr;
        last_i       <= 1'b0;
      end
      if (Dc_wb_we) begin
        if (!buf_valid || drain) begin
          buf_valid <= 1'b1;
          buf_addr  <= Dc_wb_addr;
          buf_line  <= Dc_wb_wline;
        end else begin
          Arb_wb_overflow <= 1'b1;
        end
      end else if (drain) begin
        buf_valid <= 1'b0;
      end
      F_mem_valid   <= (state == RD_I) & Arb_mem_valid;
      MEM_mem_valid <= (state == RD_D) & Arb_mem_valid;
      if ((state == RD_I) && Arb_mem_valid) F_mem_inst    <= Arb_mem_rline;
      if ((state == RD_D) && Arb_mem_valid) MEM_data_line <= Arb_mem_rline;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mem_arbiter : cycle-vector bench for mem_arbiter plus async-reset sequence. Rev 1.0
// ---------------------------------------------------------------------------
module tb_mem_arbiter;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         Ic_mem_req = 1'b0;
  logic [15:0]  Ic_mem_addr = '0;
  logic [127:0] F_mem_inst;
  logic         F_mem_valid;
  logic         Dc_mem_req = 1'b0;
  logic [15:0]  Dc_mem_addr = '0;
  logic [127:0] MEM_data_line;
  logic         MEM_mem_valid;
  logic         Dc_wb_we = 1'b0;
  logic [15:0]  Dc_wb_addr = '0;
  logic [127:0] Dc_wb_wline = '0;
  logic         Arb_mem_req;
  logic         Arb_mem_we;
  logic [15:0]  Arb_mem_addr;
  logic [127:0] Arb_mem_wline;
  logic [127:0] Arb_mem_rline = '0;
  logic         Arb_mem_valid = 1'b0;
  logic         Arb_wb_overflow;

  mem_arbiter #(.LADDR_BITS(16), .LINE_BITS(128)) dut (
    .clk(clk), .rst(rst),
    .Ic_mem_req(Ic_mem_req), .Ic_mem_addr(Ic_mem_addr),
    .F_mem_inst(F_mem_inst), .F_mem_valid(F_mem_valid),
    .Dc_mem_req(Dc_mem_req), .Dc_mem_addr(Dc_mem_addr),
    .MEM_data_line(MEM_data_line), .MEM_mem_valid(MEM_mem_valid),
    .Dc_wb_we(Dc_wb_we), .Dc_wb_addr(Dc_wb_addr), .Dc_wb_wline(Dc_wb_wline),
    .Arb_mem_req(Arb_mem_req), .Arb_mem_we(Arb_mem_we),
    .Arb_mem_addr(Arb_mem_addr), .Arb_mem_wline(Arb_mem_wline),
    .Arb_mem_rline(Arb_mem_rline), .Arb_mem_valid(Arb_mem_valid),
    .Arb_wb_overflow(Arb_wb_overflow)
  );

  always #5 clk = ~clk;

  // Inputs are applied for one cycle; expectations are the outputs seen in that same cycle.
  typedef struct {
    logic ic; logic [15:0] ia; logic dc; logic [15:0] da;
    logic we; logic [15:0] wa; logic [127:0] wl; logic mv; logic [127:0] rl;
    logic e_req; logic e_we; logic [15:0] e_addr; logic [127:0] e_wl;
    logic e_fv; logic [127:0] e_fi; logic e_mv; logic [127:0] e_ml; logic e_ovf;
  } vec_t;

  int applied = 0;
  int miscompares = 0;
  vec_t vecs[$];

  function automatic vec_t mk(
    input logic ic, input logic [15:0] ia, input logic dc, input logic [15:0] da,
    input logic we, input logic [15:0] wa, input logic [7:0] wl,
    input logic mv, input logic [7:0] rl,
    input logic e_req, input logic e_we, input logic [15:0] e_addr, input logic [7:0] e_wl,
    input logic e_fv, input logic [7:0] e_fi, input logic e_mv, input logic [7:0] e_ml,
    input logic e_ovf);
    vec_t v;
    v.ic = ic; v.ia = ia; v.dc = dc; v.da = da;
    v.we = we; v.wa = wa; v.wl = {16{wl}}; v.mv = mv; v.rl = {16{rl}};
    v.e_req = e_req; v.e_we = e_we; v.e_addr = e_addr; v.e_wl = {16{e_wl}};
    v.e_fv = e_fv; v.e_fi = {16{e_fi}}; v.e_mv = e_mv; v.e_ml = {16{e_ml}};
    v.e_ovf = e_ovf;
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int  reqcyc;
    bit  got;

    //            ic  ia      dc  da      we  wa      wl     mv rl      req we addr    wl     fv fi     mv ml     ovf
    vecs.push_back(mk(1, 16'h04, 1, 16'h20, 0, 16'h00, 8'h00, 0, 8'h00,  0, 0, 16'h00, 8'h00, 0, 8'h00, 0, 8'h00, 0));
    vecs.push_back(mk(1, 16'h04, 1, 16'h20, 0, 16'h00, 8'h00, 0, 8'h00,  1, 0, 16'h04, 8'h00, 0, 8'h00, 0, 8'h00, 0));
    vecs.push_back(mk(1, 16'h04, 1, 16'h20, 0, 16'h00, 8'h00, 0, 8'h00,  1, 0, 16'h04, 8'h00, 0, 8'h00, 0, 8'h00, 0));
    vecs.push_back(mk(1, 16'h04, 1, 16'h20, 0, 16'h00, 8'h00, 1, 8'hA5,  1, 0, 16'h04, 8'h00, 0, 8'h00, 0, 8'h00, 0));
    vecs.push_back(mk(1, 16'h04, 1, 16'h20, 0, 16'h00, 8'h00, 0, 8'h00,  0, 0, 16'h04, 8'h00, 1, 8'hA5, 0, 8'h00, 0));
    vecs.push_back(mk(0, 16'h00, 1, 16'h20, 0, 16'h00, 8'h00, 1, 8'h3C,  1, 0, 16'h20, 8'h00, 0, 8'hA5, 0, 8'h00, 0));
    vecs.push_back(mk(0, 16'h00, 1, 16'h20, 0, 16'h00, 8'h00, 0, 8'h00,  0, 0, 16'h20, 8'h00, 0, 8'hA5, 1, 8'h3C, 0));
    vecs.push_back(mk(1, 16'h40, 0, 16'h00, 0, 16'h00, 8'h00, 0, 8'h00,  0, 0, 16'h20, 8'h00, 0, 8'hA5, 0, 8'h3C, 0));
    vecs.push_back(mk(1, 16'h40, 0, 16'h00, 0, 16'h00, 8'h00, 1, 8'h11,  1, 0, 16'h40, 8'h00, 0, 8'hA5, 0, 8'h3C, 0));
    vecs.push_back(mk(0, 16'h00, 0, 16'h00, 0, 16'h00, 8'h00, 0, 8'h00,  0, 0, 16'h40, 8'h00, 1, 8'h11, 0, 8'h3C, 0));
    // I was granted last, so D wins the tie.
    vecs.push_back(mk(1, 16'h50, 1, 16'h60, 0, 16'h00, 8'h00, 0, 8'h00,  0, 0, 16'h40, 8'h00, 0, 8'h11, 0, 8'h3C, 0));
    vecs.push_back(mk(1, 16'h50, 1, 16'h60, 0, 16'h00, 8'h00, 1, 8'h22,  1, 0, 16'h60, 8'h00, 0, 8'h11, 0, 8'h3C, 0));
    vecs.push_back(mk(1, 16'h50, 1, 16'h60, 0, 16'h00, 8'h00, 0, 8'h00,  0, 0, 16'h60, 8'h00, 0, 8'h11, 1, 8'h22, 0));
    vecs.push_back(mk(1, 16'h50, 0, 16'h00, 0, 16'h00, 8'h00, 1, 8'h33,  1, 0, 16'h50, 8'h00, 0, 8'h11, 0, 8'h22, 0));
    vecs.push_back(mk(0, 16'h00, 0, 16'h00, 0, 16'h00, 8'h00, 0, 8'h00,  0, 0, 16'h50, 8'h00, 1, 8'h33, 0, 8'h22, 0));
    // Stray completion while idle must be ignored.
    vecs.push_back(mk(0, 16'h00, 0, 16'h00, 0, 16'h00, 8'h00, 1, 8'hFF,  0, 0, 16'h50, 8'h00, 0, 8'h33, 0, 8'h22, 0));
    // Write-back and read to the same line: write goes first.
    vecs.push_back(mk(0, 16'h00, 1, 16'h10, 1, 16'h10, 8'hDE, 0, 8'h00,  0, 0, 16'h50, 8'h00, 0, 8'h33, 0, 8'h22, 0));
    vecs.push_back(mk(0, 16'h00, 1, 16'h10, 0, 16'h00, 8'h00, 0, 8'h00,  0, 0, 16'h50, 8'h00, 0, 8'h33, 0, 8'h22, 0));
    vecs.push_back(mk(0, 16'h00, 1, 16'h10, 0, 16'h00, 8'h00, 1, 8'h00,  1, 1, 16'h10, 8'hDE, 0, 8'h33, 0, 8'h22, 0));
    vecs.push_back(mk(0, 16'h00, 1, 16'h10, 0, 16'h00, 8'h00, 0, 8'h00,  0, 0, 16'h10, 8'hDE, 0, 8'h33, 0, 8'h22, 0));
    vecs.push_back(mk(0, 16'h00, 1, 16'h10, 0, 16'h00, 8'h00, 1, 8'h44,  1, 0, 16'h10, 8'hDE, 0, 8'h33, 0, 8'h22, 0));
    vecs.push_back(mk(0, 16'h00, 1, 16'h10, 0, 16'h00, 8'h00, 0, 8'h00,  0, 0, 16'h10, 8'hDE, 0, 8'h33, 1, 8'h44, 0));
    // Overflow: 0x34 and 0x38 are dropped; 0x3C arrives on drain and is kept.
    vecs.push_back(mk(0, 16'h00, 0, 16'h00, 1, 16'h30, 8'hA1, 0, 8'h00,  0, 0, 16'h10, 8'hDE, 0, 8'h33, 0, 8'h44, 0));
    vecs.push_back(mk(0, 16'h00, 0, 16'h00, 1, 16'h34, 8'hB2, 0, 8'h00,  0, 0, 16'h10, 8'hDE, 0, 8'h33, 0, 8'h44, 0));
    vecs.push_back(mk(0, 16'h00, 0, 16'h00, 1, 16'h38, 8'hC3, 0, 8'h00,  1, 1, 16'h30, 8'hA1, 0, 8'h33, 0, 8'h44, 1));
    vecs.push_back(mk(0, 16'h00, 0, 16'h00, 1, 16'h3C, 8'hD4, 1, 8'h00,  1, 1, 16'h30, 8'hA1, 0, 8'h33, 0, 8'h44, 1));
    vecs.push_back(mk(0, 16'h00, 0, 16'h00, 0, 16'h00, 8'h00, 0, 8'h00,  0, 0, 16'h30, 8'hA1, 0, 8'h33, 0, 8'h44, 1));
    vecs.push_back(mk(0, 16'h00, 0, 16'h00, 0, 16'h00, 8'h00, 1, 8'h00,  1, 1, 16'h3C, 8'hD4, 0, 8'h33, 0, 8'h44, 1));
    vecs.push_back(mk(0, 16'h00, 0, 16'h00, 0, 16'h00, 8'h00, 0, 8'h00,  0, 0, 16'h3C, 8'hD4, 0, 8'h33, 0, 8'h44, 1));
    vecs.push_back(mk(0, 16'h00, 0, 16'h00, 0, 16'h00, 8'h00, 0, 8'h00,  0, 0, 16'h3C, 8'hD4, 0, 8'h33, 0, 8'h44, 1));

    repeat (3) @(negedge clk);
    chk("in_reset_ctrl", {126'd0, Arb_mem_req, Arb_mem_we}, 128'd0);
    chk("in_reset_valids", {125'd0, F_mem_valid, MEM_mem_valid, Arb_wb_overflow}, 128'd0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      chk($sformatf("v%0d_ctrl{req,we,fv,mv,ovf}", i),
          {123'd0, Arb_mem_req, Arb_mem_we, F_mem_valid, MEM_mem_valid, Arb_wb_overflow},
          {123'd0, vecs[i].e_req, vecs[i].e_we, vecs[i].e_fv, vecs[i].e_mv, vecs[i].e_ovf});
      chk($sformatf("v%0d_addr", i), {112'd0, Arb_mem_addr}, {112'd0, vecs[i].e_addr});
      chk($sformatf("v%0d_wline", i), Arb_mem_wline, vecs[i].e_wl);
      chk($sformatf("v%0d_finst", i), F_mem_inst, vecs[i].e_fi);
      chk($sformatf("v%0d_mline", i), MEM_data_line, vecs[i].e_ml);
      Ic_mem_req    = vecs[i].ic;  Ic_mem_addr   = vecs[i].ia;
      Dc_mem_req    = vecs[i].dc;  Dc_mem_addr   = vecs[i].da;
      Dc_wb_we      = vecs[i].we;  Dc_wb_addr    = vecs[i].wa;  Dc_wb_wline = vecs[i].wl;
      Arb_mem_valid = vecs[i].mv;  Arb_mem_rline = vecs[i].rl;
    end

    // Reset asserted mid-read must drop outputs without a clock edge.
    @(negedge clk);
    Dc_mem_req = 1'b1; Dc_mem_addr = 16'h0070;
    @(posedge clk); #1;
    chk("rd_d_issued", {111'd0, Arb_mem_req, Arb_mem_we, Arb_mem_addr}, {111'd0, 1'b1, 1'b0, 16'h0070});
    #2 rst = 1'b1;
    #1;
    chk("async_rst_req", {127'd0, Arb_mem_req}, 128'd0);
    chk("async_rst_valids", {125'd0, MEM_mem_valid, F_mem_valid, Arb_wb_overflow}, 128'd0);
    chk("async_rst_regs", {Arb_mem_wline[111:0], Arb_mem_addr}, 128'd0);
    chk("async_rst_lines", F_mem_inst | MEM_data_line, 128'd0);
    @(negedge clk);
    Dc_mem_req = 1'b0;
    rst = 1'b0;

    // Fresh I-fetch after reset, memory answers on the third request cycle.
    Ic_mem_req = 1'b1; Ic_mem_addr = 16'h0004;
    reqcyc = 0;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      Arb_mem_valid = 1'b0;
      if (F_mem_valid) begin
        got = 1'b1;
      end else if (Arb_mem_req) begin
        reqcyc++;
        if (reqcyc == 1)
          chk("post_rst_addr", {110'd0, Arb_mem_we, Arb_mem_req, Arb_mem_addr}, {110'd0, 1'b0, 1'b1, 16'h0004});
        if (reqcyc == 3) begin
          Arb_mem_valid = 1'b1;
          Arb_mem_rline = {16{8'h5A}};
        end
      end
    end
    chk("post_rst_served", {127'd0, got}, {127'd0, 1'b1});
    chk("post_rst_req_cycles", reqcyc, 3);
    chk("post_rst_finst", F_mem_inst, {16{8'h5A}});
    Ic_mem_req = 1'b0;
    @(negedge clk);
    chk("post_rst_single_pulse", {126'd0, F_mem_valid, Arb_mem_req}, 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
